// File: rtl/subleq_mem_arbiter.sv
// Single-port memory arbiter for the subleq core: debug port has priority, the CPU
// is protected by a starvation guard and may lock the port across a read-modify-write.
module subleq_mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    input  logic                 cpu_lock,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [WORD_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic       lock_q, lock_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    owner_t     rd_owner_q, rd_owner_d;

    // Grants are held low during reset so nothing reaches memory while areset_n is low.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (areset_n) begin
            if (lock_q && cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (cpu_req && (starve_cnt_q == BURST_LIMIT)) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        lock_d = cpu_gnt & cpu_lock;

        starve_cnt_d = starve_cnt_q;
        if (cpu_gnt || !cpu_req) begin
            starve_cnt_d = 8'd0;
        end else if (dbg_gnt && (starve_cnt_q < BURST_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        rd_owner_d = OWNER_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = OWNER_CPU;
        end else if (dbg_gnt && !dbg_we) begin
            rd_owner_d = OWNER_DBG;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            lock_q       <= 1'b0;
            starve_cnt_q <= 8'd0;
            rd_owner_q   <= OWNER_NONE;
        end else begin
            lock_q       <= lock_d;
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Read data is shared; only the owner's rvalid marks it meaningful.
    assign cpu_rvalid = (rd_owner_q == OWNER_CPU);
    assign dbg_rvalid = (rd_owner_q == OWNER_DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// [TB] Self-checking bench for subleq_mem_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model with its own memory image.
module tb_subleq_mem_arbiter;

    localparam int W   = 16;
    localparam int MAX = 8;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         cpu_req, cpu_we, cpu_lock;
    logic [W-1:0] cpu_addr, cpu_wdata;
    logic         cpu_gnt, cpu_rvalid;
    logic [W-1:0] cpu_rdata;
    logic         dbg_req, dbg_we;
    logic [W-1:0] dbg_addr, dbg_wdata;
    logic         dbg_gnt, dbg_rvalid;
    logic [W-1:0] dbg_rdata;
    logic         mem_en, mem_we;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [W-1:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    subleq_mem_arbiter #(.WORD_SIZE(W), .MAX_BURST(MAX)) dut (
        .clk(clk), .areset_n(areset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory attached to the arbiter.
    logic [W-1:0] tb_mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Reference model: memory image, lock flag, consecutive-debug-grant count, pending read.
    logic [W-1:0] ref_mem [int];
    bit           m_lock;
    int           m_starve;
    int           m_owner;      // 0 none, 1 cpu, 2 dbg
    logic [W-1:0] m_rdata;
    logic         e_cpu_gnt, e_dbg_gnt, e_mem_en, e_mem_we;
    logic [W-1:0] e_mem_addr, e_mem_wdata;

    function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    task automatic backdoor(input logic [W-1:0] a, input logic [W-1:0] d);
        tb_mem[a] = d;
        ref_mem[int'(a)] = d;
    endtask

    task automatic model_reset();
        m_lock = 0; m_starve = 0; m_owner = 0; m_rdata = '0;
    endtask

    task automatic predict();
        e_cpu_gnt = 0; e_dbg_gnt = 0;
        if (areset_n === 1'b1) begin
            if (cpu_req && (m_lock || m_starve == MAX)) e_cpu_gnt = 1;
            else if (dbg_req) e_dbg_gnt = 1;
            else if (cpu_req) e_cpu_gnt = 1;
        end
        e_mem_en    = e_cpu_gnt | e_dbg_gnt;
        e_mem_we    = e_cpu_gnt ? cpu_we    : (e_dbg_gnt ? dbg_we    : 1'b0);
        e_mem_addr  = e_cpu_gnt ? cpu_addr  : (e_dbg_gnt ? dbg_addr  : '0);
        e_mem_wdata = e_cpu_gnt ? cpu_wdata : (e_dbg_gnt ? dbg_wdata : '0);
    endtask

    task automatic advance();
        if (areset_n !== 1'b1) begin
            model_reset();
            return;
        end
        m_owner = 0;
        if (e_mem_en) begin
            if (e_mem_we) ref_mem[int'(e_mem_addr)] = e_mem_wdata;
            else begin
                m_owner = e_cpu_gnt ? 1 : 2;
                m_rdata = ref_read(e_mem_addr);
            end
        end
        m_lock = e_cpu_gnt && cpu_lock;
        if (!cpu_req || e_cpu_gnt) m_starve = 0;
        else if (e_dbg_gnt && m_starve < MAX) m_starve++;
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [W-1:0] a,
                           input logic [W-1:0] d, input logic lk);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_lock = lk;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [W-1:0] a,
                           input logic [W-1:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic go_idle();
        set_cpu(0, 0, '0, '0, 0);
        set_dbg(0, 0, '0, '0);
        tick();
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        model_reset();
        set_cpu(1, 0, 16'h0010, '0, 0);
        set_dbg(1, 0, 16'h0011, '0);
        @(negedge clk);
        tests_run++; if ({cpu_gnt, dbg_gnt, mem_en} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_grants: got %b expected 000", {cpu_gnt, dbg_gnt, mem_en}); end
        tests_run++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {cpu_rvalid, dbg_rvalid}); end
        areset_n = 1'b1;
        go_idle();

        backdoor(16'h0010, 16'h1234);
        set_cpu(1, 0, 16'h0010, '0, 0);
        @(negedge clk);
        tests_run++; if (cpu_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_midread_gnt: got %b expected 1", cpu_gnt); end
        #1 areset_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if ({cpu_gnt, mem_en} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_async_gate: got %b expected 00", {cpu_gnt, mem_en}); end
        tick();
        @(negedge clk);
        tests_run++; if (cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dropped_read: got %b expected 0", cpu_rvalid); end
        areset_n = 1'b1;
        #1;
        tests_run++; if (cpu_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_gnt: got %b expected 1", cpu_gnt); end
        tick();
        @(negedge clk);
        tests_run++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin tests_failed++; $display("[TB] FAIL post_reset_read: got rvalid=%b data=%h expected 1/1234", cpu_rvalid, cpu_rdata); end
        go_idle();
    endtask

    task automatic test_contention();
        set_cpu(1, 1, 16'h0030, 16'hBEEF, 0);
        set_dbg(1, 0, 16'h0031, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if ({dbg_gnt, cpu_gnt} !== 2'b10) begin tests_failed++; $display("[TB] FAIL contention_%0d: got dbg/cpu=%b expected 10", i, {dbg_gnt, cpu_gnt}); end
            tick();
        end
        set_dbg(0, 0, '0, '0);
        @(negedge clk);
        tests_run++; if ({dbg_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 16'h0030, 16'hBEEF}) begin tests_failed++; $display("[TB] FAIL contention_cpu_after: got gnt=%b%b we=%b a=%h d=%h expected 0 1 1 0030 beef", dbg_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata); end
        tick();
        go_idle();
    endtask

    task automatic test_starvation();
        set_cpu(1, 0, 16'h0040, '0, 0);
        set_dbg(1, 0, 16'h0041, '0);
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            tests_run++; if (cpu_gnt !== ((i % 9) == 8) || dbg_gnt !== ((i % 9) != 8)) begin tests_failed++; $display("[TB] FAIL starvation_cycle_%0d: got cpu=%b dbg=%b expected cpu=%b", i, cpu_gnt, dbg_gnt, ((i % 9) == 8)); end
            tick();
        end
        go_idle();
    endtask

    task automatic test_lock();
        backdoor(16'h0020, 16'h0005);
        set_cpu(1, 0, 16'h0020, '0, 1);
        @(negedge clk);
        tests_run++; if (cpu_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_read_gnt: got %b expected 1", cpu_gnt); end
        tick();
        set_cpu(1, 1, 16'h0020, 16'h0002, 0);
        set_dbg(1, 0, 16'h0020, '0);
        @(negedge clk);
        tests_run++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin tests_failed++; $display("[TB] FAIL lock_write_first: got cpu/dbg=%b expected 10", {cpu_gnt, dbg_gnt}); end
        tests_run++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0005) begin tests_failed++; $display("[TB] FAIL lock_read_data: got %b/%h expected 1/0005", cpu_rvalid, cpu_rdata); end
        tick();
        set_cpu(0, 0, '0, '0, 0);
        @(negedge clk);
        tests_run++; if (dbg_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_dbg_gnt: got %b expected 1", dbg_gnt); end
        tick();
        @(negedge clk);
        tests_run++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h0002) begin tests_failed++; $display("[TB] FAIL lock_dbg_data: got %b/%h expected 1/0002", dbg_rvalid, dbg_rdata); end
        go_idle();
    endtask

    task automatic test_lock_release();
        set_cpu(1, 0, 16'h0050, '0, 1);
        tick();
        set_cpu(0, 0, '0, '0, 0);
        set_dbg(1, 0, 16'h0051, '0);
        @(negedge clk);
        tests_run++; if ({dbg_gnt, cpu_gnt} !== 2'b10) begin tests_failed++; $display("[TB] FAIL lock_release_dbg: got dbg/cpu=%b expected 10", {dbg_gnt, cpu_gnt}); end
        tick();
        set_cpu(1, 0, 16'h0052, '0, 0);
        @(negedge clk);
        tests_run++; if ({dbg_gnt, cpu_gnt} !== 2'b10) begin tests_failed++; $display("[TB] FAIL lock_cleared: got dbg/cpu=%b expected 10", {dbg_gnt, cpu_gnt}); end
        tick();
        go_idle();
    endtask

    task automatic test_back_to_back();
        backdoor(16'hff01, 16'h0A0B);
        backdoor(16'hff02, 16'h0C0D);
        set_dbg(1, 1, 16'hff00, 16'h0007);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_dbg(1, 0, 16'hff00 + 16'(i), '0);
            else       set_dbg(0, 0, '0, '0);
            @(negedge clk);
            if (i > 0) begin
                tests_run++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== m_rdata) begin tests_failed++; $display("[TB] FAIL dump_read_%0d: got rv=%b cpu_rv=%b data=%h expected 1/0/%h", i - 1, dbg_rvalid, cpu_rvalid, dbg_rdata, m_rdata); end
            end
            tick();
        end
        tests_run++; if (ref_read(16'hff00) !== 16'h0007) begin tests_failed++; $display("[TB] FAIL dump_model_ff00: got %h expected 0007", ref_read(16'hff00)); end
        go_idle();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1), 16'($urandom_range(0, 7)),
                    16'($urandom), $urandom_range(0, 3) == 0);
            set_dbg($urandom_range(0, 99) < 70, $urandom_range(0, 1), 16'($urandom_range(0, 7)),
                    16'($urandom));
            @(negedge clk);
            predict();
            tests_run++;
            if ({cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
                {e_cpu_gnt, e_dbg_gnt, e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata} ||
                cpu_rvalid !== (m_owner == 1) || dbg_rvalid !== (m_owner == 2) ||
                (m_owner == 1 && cpu_rdata !== m_rdata) || (m_owner == 2 && dbg_rdata !== m_rdata)) begin
                tests_failed++;
                if (errs++ < 10) $display("[TB] FAIL random_%0d: got gnt=%b%b we=%b a=%h d=%h rv=%b%b rd=%h/%h expected gnt=%b%b we=%b a=%h d=%h owner=%0d rd=%h",
                    i, cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata,
                    e_cpu_gnt, e_dbg_gnt, e_mem_we, e_mem_addr, e_mem_wdata, m_owner, m_rdata);
            end
            tick();
        end
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = '0;
        mem_rdata = '0;
        areset_n  = 1'b0;
        set_cpu(0, 0, '0, '0, 0);
        set_dbg(0, 0, '0, '0);
        model_reset();
        #1;
        test_reset();
        test_contention();
        test_starvation();
        test_lock();
        test_lock_release();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
